// File: rtl/audio_pkg.sv
// audio_pkg: state codes and numeric helpers
// shared by the audio output stages.
package audio_pkg;

  localparam logic [1:0] ST_MUTED   = 2'b00;
  localparam logic [1:0] ST_RAMPING = 2'b01;
  localparam logic [1:0] ST_STEADY  = 2'b10;

  function automatic longint UNITY_GAIN(
    input int gainbits
  );
    return longint'(1) << (gainbits - 1);
  endfunction

  function automatic longint sat_hi(
    input int bits
  );
    return (longint'(1) << (bits - 1)) - 1;
  endfunction

  function automatic longint sat_lo(
    input int bits
  );
    return -(longint'(1) << (bits - 1));
  endfunction

endpackage

// File: rtl/output_gain_ramp_if.sv
// output_gain_ramp_if: frame clock, stereo samples,
// gain controls and status between matrix and i2s_tx.
interface output_gain_ramp_if #(
  parameter int BITSIZE  = 16,
  parameter int GAINBITS = 16
);
  logic                       lrclk;
  logic signed [BITSIZE-1:0]  in_l;
  logic signed [BITSIZE-1:0]  in_r;
  logic        [GAINBITS-1:0] gain_target;
  logic                       mute;
  logic signed [BITSIZE-1:0]  out_l;
  logic signed [BITSIZE-1:0]  out_r;
  logic                       out_valid;
  logic                       clip;
  logic        [1:0]          state;

  modport master (
    output lrclk, in_l, in_r,
    output gain_target, mute,
    input  out_l, out_r, out_valid,
    input  clip, state
  );

  modport slave (
    input  lrclk, in_l, in_r,
    input  gain_target, mute,
    output out_l, out_r, out_valid,
    output clip, state
  );
endinterface

// File: rtl/gain_saturate.sv
// gain_saturate: one channel, sample times unsigned
// Q1.x gain, rescaled and clamped to the sample range.
module gain_saturate
  import audio_pkg::*;
#(
  parameter int BITSIZE  = 16,
  parameter int GAINBITS = 16
) (
  input  logic signed [BITSIZE-1:0]  din,
  input  logic        [GAINBITS-1:0] gain,
  output logic signed [BITSIZE-1:0]  dout,
  output logic                       sat
);
  localparam int PW = BITSIZE + GAINBITS + 1;
  localparam logic signed [PW-1:0] HI =
    PW'(sat_hi(BITSIZE));
  localparam logic signed [PW-1:0] LO =
    PW'(sat_lo(BITSIZE));

  logic signed [PW-1:0] a;
  logic signed [PW-1:0] b;
  logic signed [PW-1:0] p;
  logic signed [PW-1:0] s;

  // Signed multiply by zero-extended gain, shift, clamp
  always_comb begin
    a = {{(GAINBITS+1){din[BITSIZE-1]}}, din};
    b = {{(BITSIZE+1){1'b0}}, gain};
    p = a * b;
    s = p >>> (GAINBITS - 1);
    dout = s[BITSIZE-1:0];
    sat = 1'b0;
    if (s > HI) begin
      dout = HI[BITSIZE-1:0];
      sat = 1'b1;
    end else if (s < LO) begin
      dout = LO[BITSIZE-1:0];
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/output_gain_ramp.sv
// output_gain_ramp: per-frame click-free gain ramp,
// stereo scaling with saturation and held clip flag.
module output_gain_ramp
  import audio_pkg::*;
#(
  parameter int BITSIZE   = 16,
  parameter int GAINBITS  = 16,
  parameter int STEP      = 256,
  parameter int CLIP_HOLD = 4800
) (
  input  logic bclk,
  input  logic rst,
  output_gain_ramp_if.slave bus
);
  localparam int GW = GAINBITS + 1;
  localparam int CW = $clog2(CLIP_HOLD + 1);
  localparam logic [GW-1:0] STEP_X = GW'(STEP);
  localparam logic [CW-1:0] HOLD_X = CW'(CLIP_HOLD);
  localparam logic [CW-1:0] ONE_X  = CW'(1);

  logic lrclk_q, lrclk_d;
  logic mul_q, mul_d;
  logic valid_q, valid_d;
  logic stb;

  logic signed [BITSIZE-1:0] in_l_q, in_l_d;
  logic signed [BITSIZE-1:0] in_r_q, in_r_d;
  logic signed [BITSIZE-1:0] out_l_q, out_l_d;
  logic signed [BITSIZE-1:0] out_r_q, out_r_d;
  logic signed [BITSIZE-1:0] sc_l, sc_r;
  logic sat_l, sat_r;

  logic [GW-1:0] g_q, g_d;
  logic [GW-1:0] tgt, diff, g_nxt;
  logic [1:0]    state_q, state_d, st_nxt;
  logic [CW-1:0] cnt_q, cnt_d;

  assign stb = bus.lrclk & ~lrclk_q;

  // One bounded ramp step toward the effective target
  always_comb begin
    tgt = bus.mute ? '0 : {1'b0, bus.gain_target};
    diff = (tgt >= g_q) ? tgt - g_q : g_q - tgt;
    if (diff <= STEP_X)
      g_nxt = tgt;
    else if (tgt > g_q)
      g_nxt = g_q + STEP_X;
    else
      g_nxt = g_q - STEP_X;
    if (g_nxt == '0 && tgt == '0)
      st_nxt = ST_MUTED;
    else if (g_nxt == tgt)
      st_nxt = ST_STEADY;
    else
      st_nxt = ST_RAMPING;
  end

  gain_saturate #(
    .BITSIZE (BITSIZE),
    .GAINBITS(GAINBITS)
  ) u_sat_l (
    .din (in_l_q),
    .gain(g_q[GAINBITS-1:0]),
    .dout(sc_l),
    .sat (sat_l)
  );

  gain_saturate #(
    .BITSIZE (BITSIZE),
    .GAINBITS(GAINBITS)
  ) u_sat_r (
    .din (in_r_q),
    .gain(g_q[GAINBITS-1:0]),
    .dout(sc_r),
    .sat (sat_r)
  );

  // Strobe stage latches samples and gain, next stage outputs
  always_comb begin
    lrclk_d = bus.lrclk;
    mul_d   = stb;
    valid_d = mul_q;
    in_l_d  = in_l_q;
    in_r_d  = in_r_q;
    g_d     = g_q;
    state_d = state_q;
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    cnt_d   = cnt_q;
    if (stb) begin
      in_l_d  = bus.in_l;
      in_r_d  = bus.in_r;
      g_d     = g_nxt;
      state_d = st_nxt;
    end
    if (mul_q) begin
      out_l_d = (state_q == ST_MUTED) ? '0 : sc_l;
      out_r_d = (state_q == ST_MUTED) ? '0 : sc_r;
      if (sat_l | sat_r)
        cnt_d = HOLD_X;
      else if (cnt_q != '0)
        cnt_d = cnt_q - ONE_X;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge bclk) begin
    if (rst) begin
      lrclk_q <= 1'b0;
      mul_q   <= 1'b0;
      valid_q <= 1'b0;
      in_l_q  <= '0;
      in_r_q  <= '0;
      g_q     <= '0;
      state_q <= ST_MUTED;
      out_l_q <= '0;
      out_r_q <= '0;
      cnt_q   <= '0;
    end else begin
      lrclk_q <= lrclk_d;
      mul_q   <= mul_d;
      valid_q <= valid_d;
      in_l_q  <= in_l_d;
      in_r_q  <= in_r_d;
      g_q     <= g_d;
      state_q <= state_d;
      out_l_q <= out_l_d;
      out_r_q <= out_r_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_l     = out_l_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_valid = valid_q;
  assign bus.clip      = (cnt_q != '0);
  assign bus.state     = state_q;
endmodule

// File: tb/tb_output_gain_ramp.sv
// tb_output_gain_ramp: frame-level reference model with
// per-cycle compare plus directed literal expectations.
module tb_output_gain_ramp;
  import audio_pkg::*;

  localparam int BITSIZE   = 16;
  localparam int GAINBITS  = 16;
  localparam int STEP      = 256;
  localparam int CLIP_HOLD = 4800;

  logic bclk = 1'b0;
  logic rst  = 1'b1;
  bit   chk_en = 1'b0;

  output_gain_ramp_if #(
    .BITSIZE (BITSIZE),
    .GAINBITS(GAINBITS)
  ) bus ();

  output_gain_ramp #(
    .BITSIZE  (BITSIZE),
    .GAINBITS (GAINBITS),
    .STEP     (STEP),
    .CLIP_HOLD(CLIP_HOLD)
  ) dut (
    .bclk(bclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 bclk = ~bclk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(
    input string       name,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_g, m_in_l, m_in_r, m_cnt;
  logic [1:0]  m_state;
  logic [15:0] m_out_l, m_out_r;
  bit          m_valid, m_pend, m_lr;

  function automatic void scale(
    input  int          x,
    input  int          g,
    output logic [15:0] y,
    output bit          s
  );
    longint p, q, hi, lo;
    p  = longint'(x) * longint'(g);
    q  = p >>> (GAINBITS - 1);
    hi = (longint'(1) << (BITSIZE - 1)) - 1;
    lo = -(longint'(1) << (BITSIZE - 1));
    s  = 1'b0;
    if (q > hi) begin
      q = hi;
      s = 1'b1;
    end else if (q < lo) begin
      q = lo;
      s = 1'b1;
    end
    y = q[15:0];
  endfunction

  always @(posedge bclk) begin
    int          tgt;
    bit          sl, sr;
    logic [15:0] yl, yr;
    if (rst) begin
      m_g = 0; m_cnt = 0; m_state = ST_MUTED;
      m_out_l = 0; m_out_r = 0;
      m_valid = 0; m_pend = 0; m_lr = 0;
      m_in_l = 0; m_in_r = 0;
    end else begin
      m_valid = 0;
      if (m_pend) begin
        scale(m_in_l, m_g, yl, sl);
        scale(m_in_r, m_g, yr, sr);
        m_out_l = (m_state == ST_MUTED) ? 16'h0 : yl;
        m_out_r = (m_state == ST_MUTED) ? 16'h0 : yr;
        if (sl || sr) m_cnt = CLIP_HOLD;
        else if (m_cnt > 0) m_cnt--;
        m_valid = 1;
        m_pend = 0;
      end
      if (bus.lrclk && !m_lr) begin
        tgt = bus.mute ? 0 : int'(bus.gain_target);
        if (tgt - m_g <= STEP && m_g - tgt <= STEP)
          m_g = tgt;
        else if (tgt > m_g)
          m_g += STEP;
        else
          m_g -= STEP;
        if (m_g == 0 && tgt == 0) m_state = ST_MUTED;
        else if (m_g == tgt) m_state = ST_STEADY;
        else m_state = ST_RAMPING;
        m_in_l = bus.in_l;
        m_in_r = bus.in_r;
        m_pend = 1;
      end
      m_lr = bus.lrclk;
    end
  end

  // Per-cycle compare against the model
  always @(negedge bclk) begin
    if (chk_en) begin
      check("out_valid", 16'(bus.out_valid),
            16'(m_valid));
      check("state", 16'(bus.state), 16'(m_state));
      check("out_l", bus.out_l, m_out_l);
      check("out_r", bus.out_r, m_out_r);
      check("clip", 16'(bus.clip), 16'(m_cnt != 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic frame(
    input logic [15:0] l,
    input logic [15:0] r
  );
    int lo;
    lo = $urandom_range(3, 1);
    bus.in_l  = l;
    bus.in_r  = r;
    bus.lrclk = 1'b0;
    repeat (lo) @(negedge bclk);
    bus.lrclk = 1'b1;
    repeat (2) @(negedge bclk);
  endtask

  task automatic rnd_frame();
    frame(16'($urandom), 16'($urandom));
  endtask

  task automatic do_reset();
    @(negedge bclk);
    rst = 1'b1;
    repeat (2) @(negedge bclk);
    rst = 1'b0;
  endtask

  int n_ramp, n_mut, n_clip, k;

  initial begin
    bus.lrclk = 1'b0;
    bus.in_l = '0;
    bus.in_r = '0;
    bus.gain_target = 16'h8000;
    bus.mute = 1'b0;
    repeat (3) @(negedge bclk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_state", 16'(bus.state), 16'(ST_MUTED));
    check("rst_out_l", bus.out_l, 16'h0);
    check("rst_out_r", bus.out_r, 16'h0);
    check("rst_valid", 16'(bus.out_valid), 16'h0);
    check("rst_clip", 16'(bus.clip), 16'h0);

    // startup ramp 0 -> 0x8000
    n_ramp = 0;
    for (int f = 1; f <= 128; f++) begin
      rnd_frame();
      if (f < 128 && bus.state == ST_RAMPING)
        n_ramp++;
    end
    check("ramp_frames", 16'(n_ramp), 16'd127);
    check("ramp_steady", 16'(bus.state),
          16'(ST_STEADY));
    frame(16'h1234, 16'h0);
    check("unity_out_l", bus.out_l, 16'h1234);
    check("unity_valid", 16'(bus.out_valid), 16'h1);

    // steady 0x4000
    bus.gain_target = 16'h4000;
    repeat (66) rnd_frame();
    frame(16'h4000, 16'hC000);
    check("half_state", 16'(bus.state),
          16'(ST_STEADY));
    check("half_out_l", bus.out_l, 16'h2000);
    check("half_out_r", bus.out_r, 16'hE000);
    check("half_clip", 16'(bus.clip), 16'h0);

    // saturation and clip hold at 0xFFFF
    bus.gain_target = 16'hFFFF;
    repeat (195) frame(16'h0, 16'h0);
    frame(16'h7FFF, 16'h8000);
    check("sat_out_l", bus.out_l, 16'h7FFF);
    check("sat_out_r", bus.out_r, 16'h8000);
    check("sat_clip", 16'(bus.clip), 16'h1);
    n_clip = 1;
    k = 0;
    while (bus.clip === 1'b1 && k < 4900) begin
      frame(16'h0, 16'h0);
      k++;
      if (bus.clip === 1'b1) n_clip++;
    end
    check("clip_hold", 16'(n_clip), 16'd4800);

    // mute redirect mid-ramp
    bus.gain_target = 16'h8000;
    repeat (130) rnd_frame();
    check("pre_mute", 16'(bus.state), 16'(ST_STEADY));
    n_mut = 0;
    bus.mute = 1'b1;
    for (int f = 1; f <= 64; f++) begin
      if (f == 64) frame(16'h4000, 16'h4000);
      else rnd_frame();
      if (bus.state == ST_MUTED) n_mut++;
    end
    check("mute_half", bus.out_l, 16'h2000);
    bus.mute = 1'b0;
    for (int f = 1; f <= 64; f++) begin
      rnd_frame();
      if (bus.state == ST_MUTED) n_mut++;
      if (f == 63)
        check("redir_ramp", 16'(bus.state),
              16'(ST_RAMPING));
    end
    check("redir_steady", 16'(bus.state),
          16'(ST_STEADY));
    check("never_muted", 16'(n_mut), 16'h0);
    bus.mute = 1'b1;
    repeat (127) rnd_frame();
    frame(16'h4000, 16'hC000);
    check("full_mute", 16'(bus.state), 16'(ST_MUTED));
    check("mute_out_l", bus.out_l, 16'h0);
    check("mute_out_r", bus.out_r, 16'h0);

    // no overshoot
    bus.mute = 1'b0;
    repeat (130) rnd_frame();
    bus.gain_target = 16'h8050;
    frame(16'h4000, 16'h4000);
    check("nos_state", 16'(bus.state),
          16'(ST_STEADY));
    check("nos_out_l", bus.out_l, 16'h4028);

    // reset in the cycle after the strobe
    bus.gain_target = 16'h2000;
    repeat (3) rnd_frame();
    check("pre_rst", 16'(bus.state), 16'(ST_RAMPING));
    bus.in_l = 16'h7000;
    bus.in_r = 16'h7000;
    bus.lrclk = 1'b0;
    @(negedge bclk);
    bus.lrclk = 1'b1;
    @(negedge bclk);
    rst = 1'b1;
    @(negedge bclk);
    rst = 1'b0;
    bus.lrclk = 1'b0;
    check("mr_state", 16'(bus.state), 16'(ST_MUTED));
    check("mr_out_l", bus.out_l, 16'h0);
    check("mr_out_r", bus.out_r, 16'h0);
    check("mr_clip", 16'(bus.clip), 16'h0);
    check("mr_valid", 16'(bus.out_valid), 16'h0);
    @(negedge bclk);
    check("mr_valid2", 16'(bus.out_valid), 16'h0);
    frame(16'h4000, 16'h4000);
    check("restart_st", 16'(bus.state),
          16'(ST_RAMPING));
    check("restart_out", bus.out_l, 16'h0080);

    // randomized traffic
    for (int f = 0; f < 600; f++) begin
      if ($urandom_range(19, 0) == 0) begin
        case ($urandom_range(3, 0))
          0: bus.gain_target = 16'hFFFF;
          1: bus.gain_target = 16'h0;
          2: bus.gain_target = 16'h8000;
          default: bus.gain_target = 16'($urandom);
        endcase
      end
      if ($urandom_range(29, 0) == 0)
        bus.mute = ~bus.mute;
      if ($urandom_range(149, 0) == 0)
        do_reset();
      rnd_frame();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
